// File: rtl/cpu_pkg.sv
// Shared types for the memory access unit and its lane formatter.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } mau_state_e;

  localparam logic [3:0] MEM_BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store replication, lane strobes and load byte extraction.
module mem_lane_fmt
  import cpu_pkg::*;
(
  input  logic        byte_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  // Select word pass-through or single-byte lane handling
  always_comb begin
    be_o    = MEM_BE_WORD;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    if (byte_i) begin
      be_o    = 4'b0001 << lane_i;
      wdata_o = {4{wdata_i[7:0]}};
      rdata_o = {24'h000000, rdata_i[{lane_i, 3'b000} +: 8]};
    end else begin
      be_o    = MEM_BE_WORD;
      wdata_o = wdata_i;
      rdata_o = rdata_i;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: request/ready/rvalid handshake to a multi-cycle data RAM,
// alignment check, timeout, pipeline stall and registered load write-back.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [REG_AW-1:0] req_rt,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic              err
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  mau_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic              byte_q;
  logic [1:0]        lane_q;
  logic [REG_AW-1:0] rt_q;
  logic              sup_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-3:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              wb_en_q;
  logic [REG_AW-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              done_q;
  logic              err_q;

  logic              fmt_byte_s;
  logic [1:0]        fmt_lane_s;
  logic [3:0]        fmt_be_s;
  logic [DATA_W-1:0] fmt_wdata_s;
  logic [DATA_W-1:0] fmt_rdata_s;

  // In IDLE the formatter sees the incoming request; afterwards the latched access
  assign fmt_byte_s = (state_q == IDLE) ? req_byte      : byte_q;
  assign fmt_lane_s = (state_q == IDLE) ? req_addr[1:0] : lane_q;

  mem_lane_fmt u_lane_fmt (
    .byte_i  (fmt_byte_s),
    .lane_i  (fmt_lane_s),
    .wdata_i (req_wdata),
    .rdata_i (mem_rdata),
    .be_o    (fmt_be_s),
    .wdata_o (fmt_wdata_s),
    .rdata_o (fmt_rdata_s)
  );

  assign stall = (state_q != IDLE) | ((state_q == IDLE) & req_valid & ~flush);

  // Access FSM with registered memory-side and write-back outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      lane_q      <= 2'b00;
      rt_q        <= '0;
      sup_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wb_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && !flush) begin
            we_q   <= req_we;
            byte_q <= req_byte;
            lane_q <= req_addr[1:0];
            rt_q   <= req_rt;
            sup_q  <= 1'b0;
            cnt_q  <= '0;
            if (!req_byte && (req_addr[1:0] != 2'b00)) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= req_addr[ADDR_W-1:2];
              mem_be_q    <= fmt_be_s;
              mem_wdata_q <= fmt_wdata_s;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (we_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT_R;
              sup_q   <= flush;
            end
          end else if (flush) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= IDLE;
          end else if (cnt_q == CNT_MAX) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= IDLE;
          end
        end
        WAIT_R: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_rvalid) begin
            state_q <= IDLE;
            if (!(sup_q || flush)) begin
              wb_en_q   <= 1'b1;
              wb_addr_q <= rt_q;
              wb_data_q <= fmt_rdata_s;
              done_q    <= 1'b1;
            end
          end else begin
            if (flush) begin
              sup_q <= 1'b1;
            end
            if (cnt_q == CNT_MAX) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short timeout for the abort case.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic        req_byte;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_rt;
  logic        flush;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        done;
  logic        err;

  int tests_run;
  int tests_failed;

  mem_access_unit #(
    .ADDR_W      (13),
    .DATA_W      (32),
    .REG_AW      (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rt     (req_rt),
    .flush      (flush),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic request(input logic we, input logic bt, input logic [12:0] a,
                         input logic [31:0] wd, input logic [3:0] rt);
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = bt;
    req_addr  = a;
    req_wdata = wd;
    req_rt    = rt;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_byte   = 1'b0;
    req_addr   = 13'h0000;
    req_wdata  = 32'h00000000;
    req_rt     = 4'd0;
    flush      = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h00000000;
    tick();
    tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_wb_data", wb_data, 32'h00000000);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Word store, zero-wait memory
    request(1'b1, 1'b0, 13'h0010, 32'hDEADBEEF, 4'd0);
    mem_ready = 1'b1;
    settle();
    check("st_stall_c0", {31'd0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    settle();
    check("st_mem_req", {31'd0, mem_req}, 32'd1);
    check("st_mem_we", {31'd0, mem_we}, 32'd1);
    check("st_mem_addr", {21'd0, mem_addr}, 32'h004);
    check("st_mem_be", {28'd0, mem_be}, 32'hF);
    check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("st_stall_c1", {31'd0, stall}, 32'd1);
    check("st_done_early", {31'd0, done}, 32'd0);
    tick();
    check("st_done", {31'd0, done}, 32'd1);
    check("st_mem_req_off", {31'd0, mem_req}, 32'd0);
    check("st_stall_c2", {31'd0, stall}, 32'd0);
    tick();
    check("st_done_pulse", {31'd0, done}, 32'd0);

    // Byte load from lane 3, three wait states then rvalid two cycles after ready
    mem_ready = 1'b0;
    request(1'b0, 1'b1, 13'h0013, 32'h00000000, 4'd5);
    tick();
    req_valid = 1'b0;
    settle();
    check("ldb_mem_be", {28'd0, mem_be}, 32'h8);
    check("ldb_mem_addr", {21'd0, mem_addr}, 32'h004);
    for (int c = 1; c <= 6; c++) begin
      mem_ready  = (c == 4);
      mem_rvalid = (c == 6);
      mem_rdata  = (c == 6) ? 32'hAABBCCDD : 32'h00000000;
      settle();
      check($sformatf("ldb_stall_c%0d", c), {31'd0, stall}, 32'd1);
      check($sformatf("ldb_wb_en_c%0d", c), {31'd0, wb_en}, 32'd0);
      check($sformatf("ldb_mem_req_c%0d", c), {31'd0, mem_req}, (c <= 4) ? 32'd1 : 32'd0);
      tick();
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    settle();
    check("ldb_wb_en", {31'd0, wb_en}, 32'd1);
    check("ldb_wb_addr", {28'd0, wb_addr}, 32'd5);
    check("ldb_wb_data", wb_data, 32'h000000AA);
    check("ldb_done", {31'd0, done}, 32'd1);
    tick();
    check("ldb_wb_en_pulse", {31'd0, wb_en}, 32'd0);

    // Byte store to lane 1
    request(1'b1, 1'b1, 13'h0001, 32'h12345678, 4'd0);
    mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    settle();
    check("stb_mem_be", {28'd0, mem_be}, 32'h2);
    check("stb_mem_wdata", mem_wdata, 32'h78787878);
    check("stb_mem_addr", {21'd0, mem_addr}, 32'h000);
    tick();
    check("stb_done", {31'd0, done}, 32'd1);
    mem_ready = 1'b0;
    tick();

    // Misaligned word load
    request(1'b0, 1'b0, 13'h0006, 32'h00000000, 4'd2);
    tick();
    req_valid = 1'b0;
    settle();
    check("mis_err", {31'd0, err}, 32'd1);
    check("mis_mem_req", {31'd0, mem_req}, 32'd0);
    check("mis_stall", {31'd0, stall}, 32'd0);
    check("mis_wb_en", {31'd0, wb_en}, 32'd0);
    tick();
    check("mis_err_pulse", {31'd0, err}, 32'd0);

    // Timeout: mem_ready never arrives
    request(1'b0, 1'b0, 13'h0020, 32'h00000000, 4'd1);
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      settle();
      check($sformatf("to_mem_req_c%0d", c), {31'd0, mem_req}, 32'd1);
      check($sformatf("to_err_c%0d", c), {31'd0, err}, 32'd0);
      tick();
    end
    check("to_err", {31'd0, err}, 32'd1);
    check("to_mem_req_off", {31'd0, mem_req}, 32'd0);
    check("to_stall", {31'd0, stall}, 32'd0);
    check("to_wb_en", {31'd0, wb_en}, 32'd0);
    tick();

    // Load after timeout completes normally
    request(1'b0, 1'b0, 13'h0024, 32'h00000000, 4'd3);
    mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    settle();
    check("ldw_wb_en", {31'd0, wb_en}, 32'd1);
    check("ldw_wb_addr", {28'd0, wb_addr}, 32'd3);
    check("ldw_wb_data", wb_data, 32'hCAFEF00D);
    check("ldw_done", {31'd0, done}, 32'd1);
    tick();

    // Flush in WAIT_R: data beat consumed, no write-back
    request(1'b0, 1'b0, 13'h0030, 32'h00000000, 4'd7);
    mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    mem_ready = 1'b0;
    flush     = 1'b1;
    tick();
    flush      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11223344;
    settle();
    check("fl_stall_wait", {31'd0, stall}, 32'd1);
    tick();
    mem_rvalid = 1'b0;
    settle();
    check("fl_wb_en", {31'd0, wb_en}, 32'd0);
    check("fl_done", {31'd0, done}, 32'd0);
    check("fl_stall_idle", {31'd0, stall}, 32'd0);
    check("fl_wb_data_hold", wb_data, 32'hCAFEF00D);
    tick();

    // Flush in IDLE blocks acceptance
    request(1'b0, 1'b0, 13'h0040, 32'h00000000, 4'd1);
    flush = 1'b1;
    settle();
    check("fli_stall", {31'd0, stall}, 32'd0);
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    settle();
    check("fli_mem_req", {31'd0, mem_req}, 32'd0);
    tick();

    // Reset while in REQ drops the access immediately
    request(1'b1, 1'b0, 13'h0044, 32'h55AA55AA, 4'd0);
    tick();
    req_valid = 1'b0;
    settle();
    check("rr_mem_req_pre", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    settle();
    check("rr_mem_req", {31'd0, mem_req}, 32'd0);
    check("rr_mem_wdata", mem_wdata, 32'h00000000);
    check("rr_mem_addr", {21'd0, mem_addr}, 32'd0);
    check("rr_wb_data", wb_data, 32'h00000000);
    check("rr_stall", {31'd0, stall}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rr_done_after", {31'd0, done}, 32'd0);
    check("rr_mem_req_after", {31'd0, mem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
